// File: rtl/iq_fifo.sv
// ---------------------------------------------------------------------------
// iq_fifo -- instruction queue between decode/rename and issue.
//
// Circular buffer of iq_entry_t records. Decode writes up to two entries per
// cycle; issue sees the four oldest entries and pops 1..4 of them, in order,
// per cycle. A branch redirect (flush) empties the queue in one cycle.
//
// Optional feature macro: IQ_PERF_CNT_EN (adds full/empty cycle counters).
//
// Ports:
//   clock              in   rising-edge clock
//   reset_n            in   asynchronous active-low reset
//   in_valid[1:0]      in   decode write strobes, bit 0 is the older entry
//   in_entry[2]        in   entries to enqueue
//   full               out  fewer than 2 free slots
//   flush              in   synchronous full flush (highest priority)
//   ext_valid[3:0]     out  ext_valid[i] = occupancy > i
//   insns[4]           out  insns[i] = entry at (rd_ptr + i) mod depth
//   empty              out  occupancy == 0
//   ext_enable         in   issue pops this cycle
//   ext_consumed[1:0]  in   number popped minus 1
//   perf_full_cycles   out  (IQ_PERF_CNT_EN) saturating count of full cycles
//   perf_empty_cycles  out  (IQ_PERF_CNT_EN) saturating count of empty cycles
// ---------------------------------------------------------------------------

package iq_fifo_pkg;
    typedef struct packed {
        logic [31:0] insn;      // decoded instruction word
        logic [5:0]  rob_idx;   // ROB slot
    } iq_entry_t;
endpackage

module iq_fifo
    import iq_fifo_pkg::*;
#(
    parameter int DEPTHLOG2 = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] in_valid,
    input  iq_entry_t  in_entry [2],
    output logic       full,
    input  logic       flush,
    output logic [3:0] ext_valid,
    output iq_entry_t  insns [4],
    output logic       empty,
    input  logic       ext_enable,
    input  logic [1:0] ext_consumed
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_full_cycles,
    output logic [31:0] perf_empty_cycles
`endif
);

    localparam int DEPTH = 1 << DEPTHLOG2;

    typedef logic [DEPTHLOG2-1:0] ptr_t;
    typedef logic [DEPTHLOG2:0]   cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    ptr_t      rd_ptr_q, rd_ptr_d;
    ptr_t      wr_ptr_q, wr_ptr_d;
    cnt_t      count_q,  count_d;
    iq_entry_t mem_q [DEPTH];

    cnt_t      free_slots;
    cnt_t      nrd_req, nrd;
    cnt_t      nwr_req, nwr;
    iq_entry_t first_entry;

    // ------------------------------------------------------------------
    // Status and read port: purely combinational from registered state.
    // ------------------------------------------------------------------
    assign free_slots = DEPTH_C - count_q;
    assign full       = (free_slots < cnt_t'(2));
    assign empty      = (count_q == '0);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_read
            assign ext_valid[gi] = (count_q > cnt_t'(gi));
            // ptr_t arithmetic wraps naturally across the end of the buffer.
            assign insns[gi]     = mem_q[rd_ptr_q + ptr_t'(gi)];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pop / push amounts. Both are clamped so the queue state can never
    // go out of range even if the neighbours break protocol. Free slots
    // are taken from the start of the cycle; same-cycle pops do not help.
    // ------------------------------------------------------------------
    assign nrd_req = ext_enable ? (cnt_t'(ext_consumed) + cnt_t'(1)) : '0;
    assign nrd     = (nrd_req > count_q) ? count_q : nrd_req;

    assign nwr_req = cnt_t'(in_valid[0]) + cnt_t'(in_valid[1]);
    assign nwr     = (nwr_req > free_slots) ? free_slots : nwr_req;

    // Compaction: a lone strobe on element 1 still lands at wr_ptr.
    assign first_entry = in_valid[0] ? in_entry[0] : in_entry[1];

    always_comb begin
        rd_ptr_d = rd_ptr_q + ptr_t'(nrd);
        wr_ptr_d = wr_ptr_q + ptr_t'(nwr);
        count_d  = count_q + nwr - nrd;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; occupancy qualifies every read.
    always_ff @(posedge clock) begin
        if (!flush) begin
            if (nwr >= cnt_t'(1)) begin
                mem_q[wr_ptr_q] <= first_entry;
            end
            if (nwr == cnt_t'(2)) begin
                mem_q[wr_ptr_q + ptr_t'(1)] <= in_entry[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks (simulation only). They warn rather than stop so
    // that the clamping behaviour itself can still be exercised.
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset_n && !flush) begin
            assert (nrd_req <= count_q)
                else $warning("iq_fifo: pop of %0d exceeds occupancy %0d", nrd_req, count_q);
            assert (nwr_req <= free_slots)
                else $warning("iq_fifo: write strobe dropped, %0d free slots", free_slots);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Optional performance counters; not cleared by flush.
    // ------------------------------------------------------------------
`ifdef IQ_PERF_CNT_EN
    logic [31:0] perf_full_q, perf_full_d;
    logic [31:0] perf_empty_q, perf_empty_d;

    always_comb begin
        perf_full_d  = perf_full_q;
        perf_empty_d = perf_empty_q;
        if (full && (perf_full_q != 32'hFFFF_FFFF)) begin
            perf_full_d = perf_full_q + 32'd1;
        end
        if (empty && (perf_empty_q != 32'hFFFF_FFFF)) begin
            perf_empty_d = perf_empty_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            perf_full_q  <= perf_full_d;
            perf_empty_q <= perf_empty_d;
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: doc/iq_fifo.md
Name: iq_fifo

Overview:
- Instruction queue between decode/rename and the issue stage.
- Circular buffer of iq_entry_t records (decoded instruction plus ROB slot).
- Accepts up to 2 entries per cycle from decode.
- Presents the oldest 4 entries to issue, which pops 1–4 in order per cycle.
- Flushed completely when the branch unit redirects the PC.

Parameters:
- DEPTHLOG2, 4: log2 of queue depth; depth = 2**DEPTHLOG2 entries; legal range 3..6.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid[2]  in  1 each  write strobes from decode; element 0 is older.
- in_entry[2]  in  iq_entry_t each  entries to enqueue.
- full  out  1  fewer than 2 free slots; decode must not write while high.
- flush  in  1  synchronous full flush (driven from new_pc_valid).
- ext_valid[4]  out  1 each  ext_valid[i] = 1 when occupancy > i.
- insns[4]  out  iq_entry_t each  insns[i] = entry at (rd_ptr + i) mod depth.
- empty  out  1  occupancy == 0.
- ext_enable  in  1  issue pops entries this cycle.
- ext_consumed  in  2  number popped minus 1; 0 pops 1, 3 pops 4.

Behaviour:
- State:
  - rd_ptr, wr_ptr: DEPTHLOG2 bits each, wrap modulo depth.
  - count: DEPTHLOG2+1 bits, range 0..depth.
  - storage array: not reset.
- Reset (async assert, sync deassert): rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, all ext_valid = 0. insns contents are don't-care while the matching ext_valid = 0.
- Read port:
  - Purely combinational from registered state; no same-cycle bypass.
  - An entry written at edge N is visible on insns/ext_valid after edge N.
- Pop:
  - nrd = ext_enable ? ext_consumed + 1 : 0.
  - If nrd > count, clamp to count; this is a protocol violation, flagged by a simulation assertion.
  - rd_ptr advances by nrd.
- Write:
  - Valid strobes are compacted in order; in_valid = 2'b10 writes in_entry[1] alone.
  - nwr = number of valid strobes, limited to the free slots at the start of the cycle (depth - count).
  - Strobes beyond the free slots are dropped; a simulation assertion fires.
  - Free-slot accounting does not credit same-cycle pops.
  - wr_ptr advances by nwr.
- Update: count_next = count + nwr - nrd. Simultaneous read and write is legal at any occupancy, including a write at count = depth - 2 with a 4-entry pop.
- full = (depth - count) < 2, combinational from count.
- Flush:
  - Highest priority: rd_ptr = wr_ptr = 0, count = 0.
  - Same-cycle writes and pops are discarded.
  - Outputs show empty on the next cycle.
- Wrap: index arithmetic uses natural DEPTHLOG2-bit overflow. insns[i] must read across the wrap boundary correctly, e.g. rd_ptr = 15, depth 16: insns[1] comes from slot 0.
- Ordering: strict FIFO. Entries leave in the exact order written; element 0 precedes element 1 within a cycle.

Optional Feature:
- Macro: IQ_PERF_CNT_EN.
- With it defined:
  - Adds outputs perf_full_cycles (32) and perf_empty_cycles (32).
  - Each increments on every cycle in which full or empty, respectively, is high.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are unaffected by flush.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then write A,B (both in_valid) -> next cycle ext_valid = 1,1,0,0; insns[0] = A, insns[1] = B; empty = 0; full = 0.
- Fill to 14 of 16 entries, then write 2 more -> full = 1 at count 15 and 16. Extra write at count 16 is dropped; the entry order read back is unchanged.
- Count 6: ext_enable = 1, ext_consumed = 3, plus one write in the same cycle -> count 3; insns[0] = the former 5th entry.
- rd_ptr = 14, count 4 -> insns[0..3] come from slots 14, 15, 0, 1 in order. Pop 4 -> empty = 1, rd_ptr = 2.
- Count 9, flush = 1 with in_valid = 2'b11 and ext_enable = 1 -> next cycle count 0, empty = 1, all ext_valid = 0. The next write lands in slot 0.
- Assert reset_n mid-stream at count 5 -> empty = 1 and full = 0 immediately, without waiting for a clock edge. With IQ_PERF_CNT_EN defined, perf_empty_cycles counts from 0 after release.
